// File: rtl/cmplx_alu.sv
// Pipelined complex ALU: Q1.15 multiply / conjugate-multiply / add / sub.
// Fixed 3-cycle latency, one op per cycle, results feed the data_mem write-back port.
module cmplx_alu #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned OP_WIDTH   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    op_v,
    input  logic [OP_WIDTH-1:0]     opcode,
    input  logic [ADDR_WIDTH-1:0]   wb_addr,
    input  logic [DATA_WIDTH*2-1:0] rdata0,
    input  logic [DATA_WIDTH*2-1:0] rdata1,
    input  logic                    clr_sat,
    output logic                    res_v,
    output logic [DATA_WIDTH*2-1:0] res_data,
    output logic [ADDR_WIDTH-1:0]   res_addr,
    output logic                    sat_flag,
    output logic                    bad_op,
    output logic [15:0]             op_cnt
);

    localparam int unsigned CW = DATA_WIDTH * 2;  // complex word
    localparam int unsigned PW = DATA_WIDTH * 2;  // one product
    localparam int unsigned SW = PW + 1;          // sum of two products
    localparam int unsigned RW = PW + 2;          // rounding headroom
    localparam int unsigned AW = DATA_WIDTH + 1;  // add/sub sum

    localparam logic [OP_WIDTH-1:0] OP_MULT  = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_ADD   = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_SUB   = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_CMULT = OP_WIDTH'(3);

    localparam logic signed [RW-1:0] RND  =
        {{(RW-DATA_WIDTH+1){1'b0}}, 1'b1, {(DATA_WIDTH-2){1'b0}}};
    localparam logic signed [RW-1:0] MAXV =
        {{(RW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] MINV =
        {{(RW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    // Returns {clipped, value} for a signed value clamped to DATA_WIDTH bits.
    function automatic logic [DATA_WIDTH:0] sat_w(input logic signed [RW-1:0] v);
        if (v > MAXV) begin
            return {1'b1, 1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (v < MINV) begin
            return {1'b1, 1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
        return {1'b0, v[DATA_WIDTH-1:0]};
    endfunction

    // ---------------- S1: operand capture
    logic                  s1_v;
    logic [OP_WIDTH-1:0]   s1_op;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [CW-1:0]         s1_a, s1_b;

    // S1 register: latch opcode, address and operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_op   <= '0;
            s1_addr <= '0;
            s1_a    <= '0;
            s1_b    <= '0;
        end else begin
            s1_v    <= op_v;
            s1_op   <= opcode;
            s1_addr <= wb_addr;
            s1_a    <= rdata0;
            s1_b    <= rdata1;
        end
    end

    // ---------------- S2: products and add/sub sums
    logic signed [DATA_WIDTH-1:0] ar, ai, br, bi;
    logic signed [PW-1:0]         p_rr, p_ii, p_ri, p_ir;
    logic signed [AW-1:0]         sum_re, sum_im;

    assign ar = s1_a[CW-1:DATA_WIDTH];
    assign ai = s1_a[DATA_WIDTH-1:0];
    assign br = s1_b[CW-1:DATA_WIDTH];
    assign bi = s1_b[DATA_WIDTH-1:0];

    assign p_rr = PW'(ar) * PW'(br);
    assign p_ii = PW'(ai) * PW'(bi);
    assign p_ri = PW'(ar) * PW'(bi);
    assign p_ir = PW'(ai) * PW'(br);

    // Only SUB subtracts; every other opcode carries the plain sum (unused if not ADD)
    assign sum_re = (s1_op == OP_SUB) ? {ar[DATA_WIDTH-1], ar} - {br[DATA_WIDTH-1], br}
                                      : {ar[DATA_WIDTH-1], ar} + {br[DATA_WIDTH-1], br};
    assign sum_im = (s1_op == OP_SUB) ? {ai[DATA_WIDTH-1], ai} - {bi[DATA_WIDTH-1], bi}
                                      : {ai[DATA_WIDTH-1], ai} + {bi[DATA_WIDTH-1], bi};

    logic                  s2_v;
    logic [OP_WIDTH-1:0]   s2_op;
    logic [ADDR_WIDTH-1:0] s2_addr;
    logic signed [PW-1:0]  s2_p_rr, s2_p_ii, s2_p_ri, s2_p_ir;
    logic signed [AW-1:0]  s2_sum_re, s2_sum_im;

    // S2 register: products and sums travel together with their valid bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v      <= 1'b0;
            s2_op     <= '0;
            s2_addr   <= '0;
            s2_p_rr   <= '0;
            s2_p_ii   <= '0;
            s2_p_ri   <= '0;
            s2_p_ir   <= '0;
            s2_sum_re <= '0;
            s2_sum_im <= '0;
        end else begin
            s2_v      <= s1_v;
            s2_op     <= s1_op;
            s2_addr   <= s1_addr;
            s2_p_rr   <= p_rr;
            s2_p_ii   <= p_ii;
            s2_p_ri   <= p_ri;
            s2_p_ir   <= p_ir;
            s2_sum_re <= sum_re;
            s2_sum_im <= sum_im;
        end
    end

    // ---------------- S3: combine products
    logic                  s3_v;
    logic [OP_WIDTH-1:0]   s3_op;
    logic [ADDR_WIDTH-1:0] s3_addr;
    logic signed [SW-1:0]  s3_re, s3_im;
    logic signed [AW-1:0]  s3_sum_re, s3_sum_im;

    // S3 register: CMULT flips the sign of ai*bi and swaps the cross-term subtraction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_v      <= 1'b0;
            s3_op     <= '0;
            s3_addr   <= '0;
            s3_re     <= '0;
            s3_im     <= '0;
            s3_sum_re <= '0;
            s3_sum_im <= '0;
        end else begin
            s3_v      <= s2_v;
            s3_op     <= s2_op;
            s3_addr   <= s2_addr;
            s3_sum_re <= s2_sum_re;
            s3_sum_im <= s2_sum_im;
            if (s2_op == OP_CMULT) begin
                s3_re <= {s2_p_rr[PW-1], s2_p_rr} + {s2_p_ii[PW-1], s2_p_ii};
                s3_im <= {s2_p_ir[PW-1], s2_p_ir} - {s2_p_ri[PW-1], s2_p_ri};
            end else begin
                s3_re <= {s2_p_rr[PW-1], s2_p_rr} - {s2_p_ii[PW-1], s2_p_ii};
                s3_im <= {s2_p_ri[PW-1], s2_p_ri} + {s2_p_ir[PW-1], s2_p_ir};
            end
        end
    end

    // ---------------- Output: round, saturate, select
    logic signed [RW-1:0] re_acc, im_acc, re_sh, im_sh;
    logic [DATA_WIDTH:0]  m_re, m_im, a_re, a_im;
    logic [CW-1:0]        res_data_d;
    logic                 sat_d, bad_d;

    // Round-half-up to Q1.15, clamp every candidate, then pick by opcode
    always_comb begin
        re_acc     = {s3_re[SW-1], s3_re} + RND;
        im_acc     = {s3_im[SW-1], s3_im} + RND;
        re_sh      = re_acc >>> (DATA_WIDTH - 1);
        im_sh      = im_acc >>> (DATA_WIDTH - 1);
        m_re       = sat_w(re_sh);
        m_im       = sat_w(im_sh);
        a_re       = sat_w({{(RW-AW){s3_sum_re[AW-1]}}, s3_sum_re});
        a_im       = sat_w({{(RW-AW){s3_sum_im[AW-1]}}, s3_sum_im});
        res_data_d = '0;
        sat_d      = 1'b0;
        bad_d      = 1'b0;
        case (s3_op)
            OP_MULT, OP_CMULT: begin
                res_data_d = {m_re[DATA_WIDTH-1:0], m_im[DATA_WIDTH-1:0]};
                sat_d      = m_re[DATA_WIDTH] | m_im[DATA_WIDTH];
            end
            OP_ADD, OP_SUB: begin
                res_data_d = {a_re[DATA_WIDTH-1:0], a_im[DATA_WIDTH-1:0]};
                sat_d      = a_re[DATA_WIDTH] | a_im[DATA_WIDTH];
            end
            default: bad_d = 1'b1;
        endcase
    end

    // Output register: data held across bubbles, sticky flags, completion counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_v    <= 1'b0;
            res_data <= '0;
            res_addr <= '0;
            sat_flag <= 1'b0;
            bad_op   <= 1'b0;
            op_cnt   <= '0;
        end else begin
            res_v <= s3_v;
            if (s3_v) begin
                res_data <= res_data_d;
                res_addr <= s3_addr;
            end
            // A saturating result beats a simultaneous clear
            sat_flag <= (sat_flag & ~clr_sat) | (s3_v & sat_d);
            bad_op   <= bad_op | (s3_v & bad_d);
            op_cnt   <= op_cnt + {15'd0, s3_v};
        end
    end

endmodule

// File: tb/tb_cmplx_alu.sv
// Scoreboard bench for cmplx_alu: expected results queued at issue, checked at output.
module tb_cmplx_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_v = 1'b0;
    logic [7:0]  opcode = '0;
    logic [7:0]  wb_addr = '0;
    logic [31:0] rdata0 = '0;
    logic [31:0] rdata1 = '0;
    logic        clr_sat = 1'b0;
    logic        res_v;
    logic [31:0] res_data;
    logic [7:0]  res_addr;
    logic        sat_flag;
    logic        bad_op;
    logic [15:0] op_cnt;

    cmplx_alu dut (
        .clk      (clk),
        .rst      (rst),
        .op_v     (op_v),
        .opcode   (opcode),
        .wb_addr  (wb_addr),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .clr_sat  (clr_sat),
        .res_v    (res_v),
        .res_data (res_data),
        .res_addr (res_addr),
        .sat_flag (sat_flag),
        .bad_op   (bad_op),
        .op_cnt   (op_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  addr;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        sb_e;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint clamp(input longint v, output logic clip);
        clip = 1'b1;
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        clip = 1'b0;
        return v;
    endfunction

    function automatic longint rnd(input longint v);
        return (v + 16384) >>> 15;
    endfunction

    // Reference model, straight from the arithmetic definition
    function automatic logic [31:0] model(input logic [7:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint ar, ai, br, bi, re, im;
        logic c0, c1;
        logic [15:0] r16, i16;
        ar = longint'($signed(a[31:16]));
        ai = longint'($signed(a[15:0]));
        br = longint'($signed(b[31:16]));
        bi = longint'($signed(b[15:0]));
        case (op)
            8'h00: begin re = rnd(ar*br - ai*bi); im = rnd(ar*bi + ai*br); end
            8'h01: begin re = ar + br; im = ai + bi; end
            8'h02: begin re = ar - br; im = ai - bi; end
            8'h03: begin re = rnd(ar*br + ai*bi); im = rnd(ai*br - ar*bi); end
            default: return 32'h0;
        endcase
        r16 = 16'(clamp(re, c0));
        i16 = 16'(clamp(im, c1));
        return {r16, i16};
    endfunction

    // Output monitor: exact-cycle scoreboard plus hold-on-bubble check
    always @(negedge clk) begin
        if (res_v) begin
            if (sb_q.size() == 0) begin
                check("unexpected_res_v", 64'(res_v), 64'd0);
            end else begin
                sb_e = sb_q.pop_front();
                check("res_data", 64'(res_data), 64'(sb_e.data));
                check("res_addr", 64'(res_addr), 64'(sb_e.addr));
                check("latency_cycle", 64'(cyc), 64'(sb_e.due));
                last_res = sb_e.data;
            end
        end else begin
            if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                check("res_v_missing", 64'(res_v), 64'd1);
                void'(sb_q.pop_front());
            end
            check("res_data_hold", 64'(res_data), 64'(last_res));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] addr, input logic [31:0] exp_data);
        exp_t e;
        op_v    = 1'b1;
        opcode  = op;
        rdata0  = a;
        rdata1  = b;
        wb_addr = addr;
        e.data  = exp_data;
        e.addr  = addr;
        e.due   = cyc + 4;
        sb_q.push_back(e);
        tick();
    endtask

    task automatic bubble();
        op_v = 1'b0;
        tick();
    endtask

    task automatic drain();
        op_v = 1'b0;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
        if (sb_q.size() != 0) begin
            check("drain_timeout", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
        tick();
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        op_v     = 1'b0;
        sb_q.delete();
        last_res = '0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0]  rop;
        logic [31:0] ra, rb;

        // Reset held with a saturating, illegal op presented
        rst    = 1'b1;
        op_v   = 1'b1;
        opcode = 8'h7F;
        rdata0 = 32'h8000_0000;
        rdata1 = 32'h8000_0000;
        repeat (5) tick();
        check("rst_res_v", 64'(res_v), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        check("rst_res_addr", 64'(res_addr), 64'd0);
        check("rst_sat_flag", 64'(sat_flag), 64'd0);
        check("rst_bad_op", 64'(bad_op), 64'd0);
        check("rst_op_cnt", 64'(op_cnt), 64'd0);

        // First op after reset; monitor enforces the 3-cycle latency
        rst = 1'b0;
        issue(8'h00, 32'h4000_4000, 32'h4000_4000, 8'h06, 32'h0000_4000);
        drain();
        check("mult_sat_flag", 64'(sat_flag), 64'd0);
        check("mult_op_cnt", 64'(op_cnt), 64'd1);

        // Saturation on multiply and on add, then clear
        issue(8'h00, 32'h8000_0000, 32'h8000_0000, 8'h10, 32'h7FFF_0000);
        drain();
        check("sat_mult_flag", 64'(sat_flag), 64'd1);
        issue(8'h01, 32'h7000_9000, 32'h7000_9000, 8'h11, 32'h7FFF_8000);
        drain();
        check("sat_add_flag", 64'(sat_flag), 64'd1);
        clr_sat = 1'b1;
        tick();
        clr_sat = 1'b0;
        check("sat_cleared", 64'(sat_flag), 64'd0);

        // clr_sat coinciding with a saturating completion: set wins
        issue(8'h00, 32'h8000_0000, 32'h8000_0000, 8'h12, 32'h7FFF_0000);
        bubble();
        bubble();
        clr_sat = 1'b1;
        tick();
        clr_sat = 1'b0;
        check("sat_set_wins", 64'(sat_flag), 64'd1);
        drain();
        clr_sat = 1'b1;
        tick();
        clr_sat = 1'b0;
        check("sat_cleared2", 64'(sat_flag), 64'd0);

        // Streaming: three back-to-back, a bubble, then one more
        do_reset(2);
        issue(8'h00, 32'h4000_4000, 32'h4000_4000, 8'h20, 32'h0000_4000);
        issue(8'h02, 32'h0003_0005, 32'h0001_0002, 8'h21, 32'h0002_0003);
        issue(8'h03, 32'h4000_4000, 32'h4000_4000, 8'h22, 32'h4000_0000);
        bubble();
        issue(8'h01, 32'h1234_0001, 32'h0001_FFFF, 8'h23, 32'h1235_0000);
        drain();
        check("stream_op_cnt", 64'(op_cnt), 64'd4);
        check("stream_sat_flag", 64'(sat_flag), 64'd0);

        // Unknown opcode: zero result, sticky bad_op
        issue(8'h7F, 32'h1111_2222, 32'h3333_4444, 8'h30, 32'h0000_0000);
        drain();
        check("bad_op_set", 64'(bad_op), 64'd1);
        issue(8'h01, 32'h0001_0001, 32'h0001_0001, 8'h31, 32'h0002_0002);
        drain();
        check("bad_op_sticky", 64'(bad_op), 64'd1);
        check("bad_op_cnt", 64'(op_cnt), 64'd6);

        // Random traffic with random bubbles against the model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bubble();
            end else begin
                rop = ($urandom_range(0, 9) == 0) ? 8'hA5 : 8'($urandom_range(0, 3));
                ra  = $urandom;
                rb  = $urandom;
                issue(rop, ra, rb, 8'($urandom), model(rop, ra, rb));
            end
        end
        drain();

        // Mid-stream reset discards everything in flight
        issue(8'h00, 32'h4000_4000, 32'h4000_4000, 8'h40, 32'h0000_4000);
        issue(8'h01, 32'h0001_0001, 32'h0001_0001, 8'h41, 32'h0002_0002);
        issue(8'h02, 32'h0003_0005, 32'h0001_0002, 8'h42, 32'h0002_0003);
        do_reset(2);
        repeat (6) tick();
        check("midrst_res_v", 64'(res_v), 64'd0);
        check("midrst_op_cnt", 64'(op_cnt), 64'd0);
        check("midrst_bad_op", 64'(bad_op), 64'd0);
        check("midrst_res_data", 64'(res_data), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cmplx_alu.md
# cmplx_alu

Pipelined complex-arithmetic stage directly downstream of `data_mem`. It consumes the two complex operands (`rdata0`, `rdata1`) read for each issued instruction, together with the decoded opcode and write-back address. It produces a Q1.15 complex result after a fixed 3-cycle latency, plus a write-back strobe/address pair that drives the `data_mem` write-back port (`wben`). Throughput is one operation per cycle, with no stalls.

## Interface
- `DATA_WIDTH`, 16, width of one real/imag component (Q1.15); a complex word is `DATA_WIDTH*2` bits, packed {re[31:16], im[15:0]}.
- `ADDR_WIDTH`, 8, data memory address width.
- `OP_WIDTH`, 8, opcode field width (`inst[7:0]`).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `op_v`  in  1  operands/opcode valid this cycle; caller aligns it with `data_mem` rdata (one cycle after `rden`).
- `opcode`  in  OP_WIDTH  operation select.
- `wb_addr`  in  ADDR_WIDTH  destination address (`inst[31:24]`), carried through the pipe.
- `rdata0`  in  DATA_WIDTH*2  operand A.
- `rdata1`  in  DATA_WIDTH*2  operand B.
- `clr_sat`  in  1  synchronous clear of `sat_flag`.
- `res_v`  out  1  result valid; connects to `data_mem` `wben`.
- `res_data`  out  DATA_WIDTH*2  result {re, im}.
- `res_addr`  out  ADDR_WIDTH  write-back address of `res_data`.
- `sat_flag`  out  1  sticky; set when any component of a valid result saturated.
- `bad_op`  out  1  sticky; set on an unknown opcode; cleared only by `rst`.
- `op_cnt`  out  16  count of completed (`res_v`) operations; wraps 16'hFFFF→0.

## Operation
- Opcodes:
  - 8'h00 CMPLX_MULT: A·B.
  - 8'h01 CMPLX_ADD: A+B.
  - 8'h02 CMPLX_SUB: A−B.
  - 8'h03 CMPLX_CMULT: A·conj(B).
  - Any other opcode: result 32'h0, `res_v` still asserted, `bad_op` set.
- Stage 1 (S1): register `op_v`, `opcode`, `wb_addr`, and the operands.
- Stage 2 (S2): four signed 16×16→32 products: ar·br, ai·bi, ar·bi, ai·br. Add/sub paths compute 17-bit sums `ar±br` and `ai±bi`, carried in parallel.
- Stage 3 (S3): combine products:
  - MULT: re=ar·br−ai·bi, im=ar·bi+ai·br.
  - CMULT: re=ar·br+ai·bi, im=ai·br−ar·bi.
  - Sums are 33-bit signed. Round by adding 2^14, arithmetic-shift right 15, then saturate to [16'h8000, 16'h7FFF].
  - ADD/SUB: saturate the 17-bit sum to 16 bits.
- Saturation is per component; `sat_flag` is set if either component of a valid result clipped.
- Valid bits travel with the data. Bubbles (`op_v=0`) propagate as `res_v=0`. Data registers need not be cleared on bubbles, but `res_data` must hold its last value when `res_v=0`.
- `op_cnt` increments in the same cycle `res_v` is registered high.

## Timing
- Latency: an op with `op_v` high at edge N gives `res_v`/`res_data`/`res_addr` valid after edge N+3, for every opcode.
- Throughput: back-to-back ops every cycle; no back-pressure and no ready signal.
- Reset values: `res_v`=0, `res_data`=0, `res_addr`=0, `sat_flag`=0, `bad_op`=0, `op_cnt`=0, and all internal valid bits 0.
- Reset mid-operation: all in-flight ops are discarded and no `res_v` follows for them. The first op accepted after `rst` deasserts appears 3 cycles later.
- `clr_sat` and a saturating result in the same cycle: set wins, so `sat_flag` stays 1.
- The write-back address may equal a read address issued in the same cycle. Hazard avoidance is the sequencer's job; this block does not check it.
- `op_cnt` wrap: an op completing at 16'hFFFF yields 16'h0000, with no flag.

## Test plan
- Reset: hold `rst` 5 cycles while driving `op_v`=1 → all outputs 0. Deassert `rst` and issue one MULT → `res_v` exactly 3 cycles later.
- MULT: A=32'h4000_4000, B=32'h4000_4000, `wb_addr`=8'h06 → `res_data`=32'h0000_4000, `res_addr`=8'h06, `sat_flag`=0.
- Saturation: MULT with A=B=32'h8000_0000 → `res_data`=32'h7FFF_0000 and `sat_flag`=1. Then ADD with A=B=32'h7000_9000 → 32'h7FFF_8000. Then pulse `clr_sat` → 0.
- Streaming: 3 back-to-back ops (MULT, SUB A=32'h0003_0005 B=32'h0001_0002 → 32'h0002_0003, CMULT A=B=32'h4000_4000 → 32'h4000_0000). Follow with one bubble and one ADD → `res_v` pattern 1,1,1,0,1 in order, and `op_cnt`=4.
- Unknown opcode 8'h7F → `res_v`=1, `res_data`=0, `bad_op`=1 and stays set through later good ops.
- Mid-stream reset: issue 3 ops and assert `rst` one cycle later → no `res_v` for any of them, and `op_cnt`=0.
